mul_red_sched: RTL

// - Sequencing controller for the shared 2x12b multiply/reduce datapath (Kyber dual-lane K_redu / Dilithium D_redu).
// - Accepts one job (op type, beat count), latches datapath selects for the whole job and gates the operand stream.
// - Generates out_valid/out_last aligned to the datapath result, including the per-op operand skew (7 for K_4_NTT, 1 for K_4_INTT/D_2_INTT).
// - Drains the pipeline before done, so selects never change while skewed operands are in flight.

---
 rtl/mul_red_pkg.sv | 70 +++++++
 rtl/mul_red_vpipe.sv | 42 ++++
 rtl/mul_red_sched.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mul_red_pkg.sv
// Shared definitions for the multiply/reduce sequencing controller:
// op encodings, FSM states, datapath select bundle and per-op skew.
package mul_red_pkg;

    localparam int SKEW_K4_NTT = 7;
    localparam int SKEW_INTT   = 1;
    localparam int SKEW_MAX    = SKEW_K4_NTT;

    typedef enum logic [2:0] {
        OP_K2_NTT  = 3'd0,
        OP_K4_NTT  = 3'd1,
        OP_K4_INTT = 3'd2,
        OP_K2_INTT = 3'd3,
        OP_D2_NTT  = 3'd4,
        OP_D2_INTT = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Datapath select bundle, held constant for a whole job.
    typedef struct packed {
        logic       mul_red_mode;  // 0 K_redu, 1 D_redu
        logic [1:0] sel_a;
        logic       sel_d_2_intt;
        logic       sel_k_4_ntt;
    } sel_t;

    function automatic sel_t op_to_sel(input logic [2:0] op);
        sel_t s;
        s = '0;
        case (op)
            OP_K4_NTT: begin
                s.sel_a       = 2'd1;
                s.sel_k_4_ntt = 1'b1;
            end
            OP_K4_INTT: begin
                s.sel_a = 2'd2;
            end
            OP_D2_NTT: begin
                s.mul_red_mode = 1'b1;
            end
            OP_D2_INTT: begin
                s.mul_red_mode = 1'b1;
                s.sel_a        = 2'd2;
                s.sel_d_2_intt = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    // Extra operand skew the datapath adds on top of its base latency.
    function automatic logic [3:0] op_skew(input logic [2:0] op);
        logic [3:0] k;
        k = 4'd0;
        case (op)
            OP_K4_NTT:  k = 4'(SKEW_K4_NTT);
            OP_K4_INTT: k = 4'(SKEW_INTT);
            OP_D2_INTT: k = 4'(SKEW_INTT);
            default:    k = 4'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/mul_red_vpipe.sv
// {valid,last} delay line with a runtime tap. Stages past the tap are
// forced empty so a later job with a deeper tap never sees stale entries.
module mul_red_vpipe #(
    parameter int DEPTH = 10,
    parameter int TAP_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [TAP_W-1:0] tap,
    output logic             out_valid,
    output logic             out_last,
    output logic             pre_last
);

    logic [DEPTH-1:0] v_q;
    logic [DEPTH-1:0] l_q;

    // Shift entries toward the tap; anything beyond the tap is dropped.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every stage is reset, not just the tap, because a reset
        // mid-job must discard all in-flight results.
        if (rst) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q[0] <= in_valid;
            l_q[0] <= in_valid & in_last;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= (TAP_W'(i) <= tap) ? v_q[i-1] : 1'b0;
                l_q[i] <= (TAP_W'(i) <= tap) ? l_q[i-1] : 1'b0;
            end
        end
    end

    assign out_valid = v_q[tap];
    assign out_last  = l_q[tap];
    // Final result reaches the tap on the next cycle.
    assign pre_last  = (tap == '0) ? (in_valid & in_last) : l_q[tap - TAP_W'(1)];

endmodule

// File: rtl/mul_red_sched.sv
// Job sequencer for the shared 2x12b multiply/reduce datapath: latches
// selects, gates operand beats, aligns out_valid/out_last with the result
// and drains the pipe before signalling done.
module mul_red_sched
    import mul_red_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int LEN_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err_op,
    output logic             out_valid,
    output logic             out_last,
    output logic             mul_Red_mode,
    output logic [1:0]       sel_a,
    output logic             sel_D_2_INTT,
    output logic             sel_K_4_NTT
);

    localparam int DEPTH = MUL_LAT + SKEW_MAX;
    localparam int TAP_W = $clog2(DEPTH);

    state_e           state;
    sel_t             sel_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt;
    logic [TAP_W-1:0] tap_q;
    logic             beat;
    logic             beat_last;
    logic             pre_last;

    assign beat      = in_valid & in_ready;
    assign beat_last = (cnt == len_q - LEN_W'(1));

    // Job FSM with beat counter, select/tap latch and registered handshakes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            len_q    <= '0;
            cnt      <= '0;
            tap_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err_op   <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every branch below sees the
            // pre-edge values of state/cnt regardless of statement order.
            done   <= 1'b0;
            err_op <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (op > 3'd5) begin
                            err_op <= 1'b1;
                        end else if (len == '0) begin
                            busy  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            sel_q    <= op_to_sel(op);
                            tap_q    <= TAP_W'(MUL_LAT + int'(op_skew(op)) - 1);
                            len_q    <= len;
                            cnt      <= '0;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                            state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (beat) begin
                        cnt <= cnt + LEN_W'(1);
                        if (beat_last) begin
                            in_ready <= 1'b0;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Enter DONE as the final result hits the output, so
                    // done follows out_last by exactly one cycle.
                    if (pre_last || out_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mul_red_vpipe #(
        .DEPTH (DEPTH),
        .TAP_W (TAP_W)
    ) u_vpipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (beat),
        .in_last   (beat_last),
        .tap       (tap_q),
        .out_valid (out_valid),
        .out_last  (out_last),
        .pre_last  (pre_last)
    );

    assign mul_Red_mode = sel_q.mul_red_mode;
    assign sel_a        = sel_q.sel_a;
    assign sel_D_2_INTT = sel_q.sel_d_2_intt;
    assign sel_K_4_NTT  = sel_q.sel_k_4_ntt;

endmodule
